reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_if.sv | 31 +++
 rtl/reg_scoreboard.sv | 96 +++++++++
 tb/tb_reg_scoreboard.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/kill handshake bundle between the pipeline and the register scoreboard.
interface reg_scoreboard_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        id_writes_rd;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        kill_valid;
  logic [4:0]  kill_rd;
  logic        id_issue;
  logic        id_stall;
  logic [31:0] busy_mask;
  logic        err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_writes_rd,
           flush, wb_valid, wb_rd, kill_valid, kill_rd,
    input  id_issue, id_stall, busy_mask, err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_writes_rd,
           flush, wb_valid, wb_rd, kill_valid, kill_rd,
    output id_issue, id_stall, busy_mask, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters gating decode issue on RAW/WAW-saturation
// hazards, with a sticky underflow error flag.
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input logic              clk,
  input logic              reset,
  reg_scoreboard_if.slave  sb
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt     [32];
  logic [CNT_W-1:0] cnt_nxt [32];
  logic             err_q;
  logic             underflow;
  logic             hazard;
  logic             issue;
  logic             stall;
  logic [31:0]      busy;

  // Hazard looks only at registered counters; same-cycle writebacks are not bypassed.
  always_comb begin
    hazard = 1'b0;
    if (sb.id_valid) begin
      hazard = (sb.id_uses_rs1  && (sb.id_rs1 != 5'd0) && (cnt[sb.id_rs1] != CNT_ZERO)) ||
               (sb.id_uses_rs2  && (sb.id_rs2 != 5'd0) && (cnt[sb.id_rs2] != CNT_ZERO)) ||
               (sb.id_writes_rd && (sb.id_rd  != 5'd0) && (cnt[sb.id_rd]  == CNT_MAX));
    end else begin
      hazard = 1'b0;
    end
  end

  // Issue/stall decision, suppressed during reset and on flush.
  always_comb begin
    issue = 1'b0;
    stall = 1'b0;
    if (!reset && sb.id_valid && !sb.flush) begin
      issue = !hazard;
      stall = hazard;
    end else begin
      issue = 1'b0;
      stall = 1'b0;
    end
  end

  // Counter next-state: inc and dec net out at CNT_W+1 bits; a net negative clamps to zero.
  always_comb begin
    logic [CNT_W:0] sum;
    logic [CNT_W:0] dec;
    logic           inc;
    sum        = {(CNT_W+1){1'b0}};
    dec        = {(CNT_W+1){1'b0}};
    inc        = 1'b0;
    underflow  = 1'b0;
    cnt_nxt[0] = CNT_ZERO;
    for (int i = 1; i < 32; i++) begin
      inc = issue && sb.id_writes_rd && (sb.id_rd == 5'(i));
      dec = (CNT_W+1)'(sb.wb_valid && (sb.wb_rd == 5'(i))) +
            (CNT_W+1)'(sb.kill_valid && (sb.kill_rd == 5'(i)));
      sum = {1'b0, cnt[i]} + (CNT_W+1)'(inc);
      if (sum < dec) begin
        cnt_nxt[i] = CNT_ZERO;
        underflow  = 1'b1;
      end else begin
        cnt_nxt[i] = CNT_W'(sum - dec);
      end
    end
  end

  // Counter and sticky error state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '{default: CNT_ZERO};
      err_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      err_q <= err_q | underflow;
    end
  end

  // Busy view of the registered counters.
  always_comb begin
    busy = 32'd0;
    for (int i = 1; i < 32; i++) begin
      busy[i] = (cnt[i] != CNT_ZERO);
    end
  end

  assign sb.id_issue  = issue;
  assign sb.id_stall  = stall;
  assign sb.busy_mask = reset ? 32'd0 : busy;
  assign sb.err       = reset ? 1'b0 : err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with CNT_W=2: RAW, x0, WAW saturation, simultaneous events,
// flush/kill and mid-flight reset.
module tb_reg_scoreboard;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  reg_scoreboard_if sb ();

  reg_scoreboard #(.CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sb.id_valid = 1'b0; sb.id_rs1 = 5'd0; sb.id_rs2 = 5'd0; sb.id_rd = 5'd0;
    sb.id_uses_rs1 = 1'b0; sb.id_uses_rs2 = 1'b0; sb.id_writes_rd = 1'b0;
    sb.flush = 1'b0; sb.wb_valid = 1'b0; sb.wb_rd = 5'd0;
    sb.kill_valid = 1'b0; sb.kill_rd = 5'd0;
  endtask

  task automatic wr(input logic [4:0] rd);
    idle();
    sb.id_valid = 1'b1; sb.id_writes_rd = 1'b1; sb.id_rd = rd;
  endtask

  task automatic rd1(input logic [4:0] rs);
    idle();
    sb.id_valid = 1'b1; sb.id_uses_rs1 = 1'b1; sb.id_rs1 = rs;
  endtask

  // Advance one edge, then settle away from it; inputs are applied before the #1 settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    wr(5'd4);
    #1;
    chk("rst_busy", sb.busy_mask, 32'd0);
    chk("rst_err", {31'd0, sb.err}, 32'd0);
    chk("rst_issue", {31'd0, sb.id_issue}, 32'd0);
    chk("rst_stall", {31'd0, sb.id_stall}, 32'd0);
    reset = 1'b0;
    idle();
    tick();

    // RAW on x5
    wr(5'd5); #1;
    chk("raw_c0_issue", {31'd0, sb.id_issue}, 32'd1);
    tick();
    rd1(5'd5); #1;
    chk("raw_c1_stall", {31'd0, sb.id_stall}, 32'd1);
    chk("raw_c1_issue", {31'd0, sb.id_issue}, 32'd0);
    chk("raw_c1_busy", sb.busy_mask, 32'h0000_0020);
    tick();
    #1;
    chk("raw_c2_stall", {31'd0, sb.id_stall}, 32'd1);
    tick();
    sb.wb_valid = 1'b1; sb.wb_rd = 5'd5; #1;
    chk("raw_c3_stall", {31'd0, sb.id_stall}, 32'd1);
    tick();
    sb.wb_valid = 1'b0; #1;
    chk("raw_c4_issue", {31'd0, sb.id_issue}, 32'd1);
    chk("raw_c4_busy", sb.busy_mask, 32'd0);
    tick();

    // x0 never tracked
    wr(5'd0);
    sb.id_uses_rs1 = 1'b1; sb.id_rs1 = 5'd0;
    sb.wb_valid = 1'b1; sb.wb_rd = 5'd0; sb.kill_valid = 1'b1; sb.kill_rd = 5'd0; #1;
    chk("x0_issue", {31'd0, sb.id_issue}, 32'd1);
    chk("x0_stall", {31'd0, sb.id_stall}, 32'd0);
    tick();
    rd1(5'd0); #1;
    chk("x0_issue2", {31'd0, sb.id_issue}, 32'd1);
    chk("x0_busy", sb.busy_mask, 32'd0);
    chk("x0_err", {31'd0, sb.err}, 32'd0);
    tick();

    // WAW saturation on x7
    for (int k = 0; k < 3; k++) begin
      wr(5'd7); #1;
      chk("waw_issue", {31'd0, sb.id_issue}, 32'd1);
      tick();
    end
    wr(5'd7); #1;
    chk("waw_sat_stall", {31'd0, sb.id_stall}, 32'd1);
    chk("waw_busy", sb.busy_mask, 32'h0000_0080);
    tick();
    sb.wb_valid = 1'b1; sb.wb_rd = 5'd7; #1;
    chk("waw_wb_stall", {31'd0, sb.id_stall}, 32'd1);
    tick();
    sb.wb_valid = 1'b0; #1;
    chk("waw_wb_issue", {31'd0, sb.id_issue}, 32'd1);
    tick();
    idle();
    sb.id_valid = 1'b1; sb.id_uses_rs2 = 1'b1; sb.id_rs2 = 5'd7; #1;
    chk("rs2_stall", {31'd0, sb.id_stall}, 32'd1);
    sb.id_uses_rs2 = 1'b0; #1;
    chk("rs2_unused_issue", {31'd0, sb.id_issue}, 32'd1);
    chk("waw_err", {31'd0, sb.err}, 32'd0);
    tick();

    // Simultaneous events on x9 (x7 still holds 3)
    wr(5'd9); #1;
    tick();
    wr(5'd9); sb.wb_valid = 1'b1; sb.wb_rd = 5'd9; #1;
    chk("x9_net_issue", {31'd0, sb.id_issue}, 32'd1);
    tick();
    idle(); #1;
    chk("x9_net_busy", sb.busy_mask, 32'h0000_0280);
    chk("x9_net_err", {31'd0, sb.err}, 32'd0);
    sb.wb_valid = 1'b1; sb.wb_rd = 5'd9; sb.kill_valid = 1'b1; sb.kill_rd = 5'd9; #1;
    tick();
    idle(); #1;
    chk("x9_uf_busy", sb.busy_mask, 32'h0000_0080);
    chk("x9_uf_err", {31'd0, sb.err}, 32'd1);
    tick();
    chk("err_sticky", {31'd0, sb.err}, 32'd1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst2_err", {31'd0, sb.err}, 32'd0);

    // Flush with hazard, then kill
    wr(5'd3); #1;
    tick();
    rd1(5'd3); sb.id_writes_rd = 1'b1; sb.id_rd = 5'd3; sb.flush = 1'b1; #1;
    chk("flush_issue", {31'd0, sb.id_issue}, 32'd0);
    chk("flush_stall", {31'd0, sb.id_stall}, 32'd0);
    tick();
    idle(); #1;
    chk("flush_busy", sb.busy_mask, 32'h0000_0008);
    sb.kill_valid = 1'b1; sb.kill_rd = 5'd3; #1;
    tick();
    idle(); #1;
    chk("kill_busy", sb.busy_mask, 32'd0);
    chk("kill_err", {31'd0, sb.err}, 32'd0);

    // Reset mid-flight
    wr(5'd1); #1; tick();
    wr(5'd2); #1; tick();
    wr(5'd31); #1; tick();
    idle(); #1;
    chk("mf_busy", sb.busy_mask, 32'h8000_0006);
    reset = 1'b1; wr(5'd4); sb.wb_valid = 1'b1; sb.wb_rd = 5'd1; #1;
    tick();
    chk("mf_rst_busy", sb.busy_mask, 32'd0);
    reset = 1'b0;
    rd1(5'd31); #1;
    chk("mf_post_issue", {31'd0, sb.id_issue}, 32'd1);
    chk("mf_post_stall", {31'd0, sb.id_stall}, 32'd0);
    chk("mf_post_err", {31'd0, sb.err}, 32'd0);
    chk("mf_post_busy", sb.busy_mask, 32'd0);
    tick();
    idle(); #1;
    chk("mf_final_busy", sb.busy_mask, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
